// File: rtl/frog_river_ctrl.sv
// Frog-on-river controller: judges whether the frog stands on the float, carries it
// along with each float step, and pulses death on a miss or when carried off at wrap.
module frog_river_ctrl #(
  parameter int c_RIVER_Y   = 5,
  parameter int c_MIN_X     = 0,
  parameter int c_MAX_X     = 13,
  parameter int c_GRACE_CYC = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [5:0] i_Frog_X,
  input  logic [5:0] i_Frog_Y,
  input  logic       i_Frog_Moved,
  input  logic [5:0] i_Floating_X,
  input  logic [5:0] i_Floating_Y,
  input  logic       i_Respawn,
  output logic       o_Riding,
  output logic       o_Carry,
  output logic [5:0] o_Carry_X,
  output logic       o_Death,
  output logic [1:0] o_State
);
  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, RIDE = 2'd2, DEAD = 2'd3} state_t;

  localparam int         CW      = (c_GRACE_CYC < 1) ? 1 : $clog2(c_GRACE_CYC + 1);
  localparam logic [5:0] RIVER_Y = 6'(c_RIVER_Y);
  localparam logic [5:0] MIN_X   = 6'(c_MIN_X);
  localparam logic [5:0] MAX_X   = 6'(c_MAX_X);
  localparam logic [CW-1:0] GRACE = CW'(c_GRACE_CYC);

  state_t        r_State;
  logic [5:0]    r_Float_Prev_X;
  logic          r_Prev_Vld;
  logic          r_Skip;
  logic [CW-1:0] r_Grace;

  logic w_Step, w_Wrap, w_On_Float, w_On_River;

  // r_Prev_Vld masks the first cycle after reset so a stale previous X is never a step
  assign w_Step     = r_Prev_Vld && (i_Floating_X != r_Float_Prev_X);
  assign w_Wrap     = w_Step && (i_Floating_X == MAX_X) && (r_Float_Prev_X == MIN_X);
  assign w_On_Float = (i_Frog_Y == i_Floating_Y) && (i_Frog_X == i_Floating_X);
  assign w_On_River = (i_Frog_Y == RIVER_Y);

  assign o_Riding = (r_State == RIDE);
  assign o_State  = r_State;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State        <= IDLE;
      r_Float_Prev_X <= '0;
      r_Prev_Vld     <= 1'b0;
      r_Skip         <= 1'b0;
      r_Grace        <= '0;
      o_Carry        <= 1'b0;
      o_Carry_X      <= '0;
      o_Death        <= 1'b0;
    end else begin
      r_Float_Prev_X <= i_Floating_X;
      r_Prev_Vld     <= 1'b1;
      o_Carry        <= 1'b0;
      o_Death        <= 1'b0;
      r_Skip         <= 1'b0;
      if (i_Respawn) begin
        r_State <= IDLE;
      end else begin
        unique case (r_State)
          IDLE: begin
            if (w_On_River) begin
              r_State <= CHECK;
              r_Grace <= GRACE;
            end
          end
          CHECK: begin
            if (!w_On_River)        r_State <= IDLE;
            else if (w_On_Float)    r_State <= RIDE;
            else if (i_Frog_Moved)  r_Grace <= GRACE;
            else if (r_Grace == '0) begin
              r_State <= DEAD;
              o_Death <= 1'b1;
            end else                r_Grace <= r_Grace - CW'(1);
          end
          RIDE: begin
            // a player move outranks a coincident float step: the frog must re-land
            if (!w_On_River) r_State <= IDLE;
            else if (i_Frog_Moved) begin
              r_State <= CHECK;
              r_Grace <= GRACE;
            end else if (w_Wrap) begin
              r_State <= DEAD;
              o_Death <= 1'b1;
            end else if (w_Step) begin
              o_Carry   <= 1'b1;
              o_Carry_X <= i_Floating_X;
              r_Skip    <= 1'b1;
            end else if (!r_Skip && !w_On_Float) begin
              // frog logic has not caught up only on the cycle right after a carry
              r_State <= CHECK;
              r_Grace <= GRACE;
            end
          end
          DEAD: ;
          default: r_State <= IDLE;
        endcase
      end
    end
  end
endmodule
